mb_atm: RTL and testbench
=========================

// Module: mb_atm
// PURPOSE
//  ATM ("Multibanco") session controller: card session, PIN check with
//  lockout, then balance query, withdrawal, deposit or exit on a 4-bit
//  account balance. Sits between keypad/card inputs and the display/dispenser
//  logic. Drives a 5-bit screen code, the cash value, the balance and a parity bit.
// PARAMETERS
//  PIN_CODE   4'b1010  correct PIN value
//  MAX_TRIES  3        wrong PIN entries before lockout
// PORTS
//  CLK        in   1  clock; all state changes on rising edge
//  RST_N      in   1  reset; asynchronous, active-low
//  EN         in   1  card inserted / session enable (level)
//  OK         in   1  confirm strobe, one-cycle pulse per keypad entry
//  PIN        in   4  entered PIN, sampled on OK in PIN state
//  COD        in   2  operation: 00 balance, 01 withdraw, 10 deposit, 11 exit
//  VAL        in   4  amount for withdraw/deposit, sampled on OK
//  SALDO      in   4  account balance, loaded at session start
//  COD_OUT    out  2  last executed operation code
//  VAL_OUT    out  4  amount dispensed by last withdraw, else 0
//  SALDO_OUT  out  4  current internal balance
//  ECRA       out  5  screen code, see below
//  PAR        out  1  even-parity bit: ^SALDO_OUT
// BEHAVIOUR
//  - All outputs registered. RST_N low: state IDLE; COD_OUT, VAL_OUT,
//    SALDO_OUT, ECRA, PAR and the try counter all 0.
//  - ECRA codes: 0 OFF, 1 ENTER_PIN, 2 PIN_WRONG, 3 BLOCKED, 4 MENU,
//    5 SHOW_BAL, 6 WDRAW_OK, 7 DEP_OK, 8 INSUFFICIENT, 9 OVERFLOW,
//    10 INVALID_VAL, 11 GOODBYE. Codes 12-31 unused.
//  - EN low in any state: IDLE on next edge; outputs cleared as on reset.
//  - IDLE: EN high -> PIN. Balance register <= SALDO; tries <= 0; ECRA=1.
//  - PIN, on OK:
//    - PIN==PIN_CODE -> MENU, ECRA=4.
//    - Otherwise tries+1, ECRA=2. If tries reaches MAX_TRIES -> BLOCK, ECRA=3.
//  - BLOCK: stays until EN low. OK ignored.
//  - MENU, on OK: COD_OUT<=COD; VAL_OUT<=0 unless withdraw succeeds.
//    - 00: ECRA=5.
//    - 01: 0<VAL<=bal -> bal-=VAL, VAL_OUT=VAL, ECRA=6.
//          VAL==0 -> ECRA=10. VAL>bal -> ECRA=8, bal unchanged.
//    - 10: VAL==0 -> ECRA=10. bal+VAL>15 (5-bit sum) -> ECRA=9, bal unchanged.
//          Otherwise bal+=VAL, ECRA=7.
//    - 11: -> BYE, ECRA=11.
//    Stays in MENU after ops 00-10. Result screen holds until the next OK.
//  - BYE: holds until EN low.
//  - Latency: one clock from OK to updated outputs. OK without EN is ignored.
//  - SALDO is sampled only at session start; later changes are ignored.
//  - PAR always tracks SALDO_OUT combinationally from its register.
// STRUCTURE
//  - Shared package mb_pkg: state enum (IDLE, PIN, MENU, BLOCK, BYE),
//    ECRA code constants, COD operation constants.
//  - One sub-module: mb_alu. Performs the withdraw/deposit compare and
//    add/sub and returns new balance plus status code. The FSM stays in mb_atm.
// TESTING
//  1. RST_N=0 mid-session -> all outputs 0 immediately; IDLE after release.
//  2. EN=1, SALDO=15, PIN=1010+OK, COD=01, VAL=5+OK -> VAL_OUT=5,
//     SALDO_OUT=10, PAR=0, ECRA=6, COD_OUT=01.
//  3. Three OKs with PIN=0000 -> ECRA 2,2,3. Further OK with correct PIN
//     -> still 3. EN=0 -> ECRA=0.
//  4. SALDO=3, withdraw VAL=4 -> ECRA=8, SALDO_OUT=3, VAL_OUT=0.
//     Withdraw VAL=0 -> ECRA=10.
//  5. SALDO=12, deposit VAL=3 -> SALDO_OUT=15, PAR=0, ECRA=7.
//     Deposit VAL=1 -> ECRA=9, SALDO_OUT=15.
//  6. COD=00 -> ECRA=5, COD_OUT=00. COD=11 -> ECRA=11; later OKs ignored.

Source files
------------

// File: rtl/mb_pkg.sv
// Shared definitions for the ATM session controller.
//   state_t   : session FSM states
//   SCR_*     : 5-bit screen codes driven on ECRA
//   OP_*      : 2-bit operation codes on COD / COD_OUT
//   alu_res_t : result bundle returned by mb_alu
package mb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PIN   = 3'd1,
    ST_MENU  = 3'd2,
    ST_BLOCK = 3'd3,
    ST_BYE   = 3'd4
  } state_t;

  localparam logic [4:0] SCR_OFF          = 5'd0;
  localparam logic [4:0] SCR_ENTER_PIN    = 5'd1;
  localparam logic [4:0] SCR_PIN_WRONG    = 5'd2;
  localparam logic [4:0] SCR_BLOCKED      = 5'd3;
  localparam logic [4:0] SCR_MENU         = 5'd4;
  localparam logic [4:0] SCR_SHOW_BAL     = 5'd5;
  localparam logic [4:0] SCR_WDRAW_OK     = 5'd6;
  localparam logic [4:0] SCR_DEP_OK       = 5'd7;
  localparam logic [4:0] SCR_INSUFFICIENT = 5'd8;
  localparam logic [4:0] SCR_OVERFLOW     = 5'd9;
  localparam logic [4:0] SCR_INVALID_VAL  = 5'd10;
  localparam logic [4:0] SCR_GOODBYE      = 5'd11;

  localparam logic [1:0] OP_BAL   = 2'b00;
  localparam logic [1:0] OP_WDRAW = 2'b01;
  localparam logic [1:0] OP_DEP   = 2'b10;
  localparam logic [1:0] OP_EXIT  = 2'b11;

  typedef struct packed {
    logic [3:0] bal;   // balance after the operation
    logic [3:0] cash;  // amount dispensed (withdraw success only)
    logic [4:0] scr;   // resulting screen code
  } alu_res_t;

endpackage

// File: rtl/mb_alu.sv
// Combinational balance arithmetic for one menu operation.
//   op  : operation code (OP_*)
//   val : requested amount
//   bal : current balance
//   res : new balance, dispensed cash and screen code
// Failed operations return the balance unchanged and zero cash.
module mb_alu
  import mb_pkg::*;
(
  input  logic [1:0] op,
  input  logic [3:0] val,
  input  logic [3:0] bal,
  output alu_res_t   res
);

  logic [4:0] sum;

  // One extra bit so a deposit that wraps past 15 is detectable.
  assign sum = {1'b0, bal} + {1'b0, val};

  always_comb begin
    res.bal  = bal;
    res.cash = 4'd0;
    res.scr  = SCR_SHOW_BAL;
    case (op)
      OP_BAL: res.scr = SCR_SHOW_BAL;
      OP_WDRAW: begin
        if (val == 4'd0) begin
          res.scr = SCR_INVALID_VAL;
        end else if (val > bal) begin
          res.scr = SCR_INSUFFICIENT;
        end else begin
          res.bal  = bal - val;
          res.cash = val;
          res.scr  = SCR_WDRAW_OK;
        end
      end
      OP_DEP: begin
        if (val == 4'd0) begin
          res.scr = SCR_INVALID_VAL;
        end else if (sum > 5'd15) begin
          res.scr = SCR_OVERFLOW;
        end else begin
          res.bal = sum[3:0];
          res.scr = SCR_DEP_OK;
        end
      end
      default: res.scr = SCR_GOODBYE;
    endcase
  end

endmodule

// File: rtl/mb_atm.sv
// ATM session controller: card session, PIN check with lockout, then
// balance / withdraw / deposit / exit on a 4-bit balance.
//   CLK, RST_N : clock, asynchronous active-low reset
//   EN         : card inserted (level); low returns to IDLE and clears outputs
//   OK         : confirm strobe; PIN, COD and VAL are sampled when it is high
//   PIN        : entered PIN
//   COD, VAL   : operation code and amount
//   SALDO      : account balance, loaded only at session start
//   COD_OUT    : last executed operation code
//   VAL_OUT    : cash dispensed by the last withdraw, else 0
//   SALDO_OUT  : current balance
//   ECRA       : screen code
//   PAR        : XOR of SALDO_OUT bits
// Handshake: OK is a one-cycle strobe with no back-pressure; every OK seen
// while EN is high is consumed on that edge and its result is visible on the
// outputs one clock later. OK while EN is low has no effect.
module mb_atm
  import mb_pkg::*;
#(
  parameter logic [3:0] PIN_CODE  = 4'b1010,
  parameter int         MAX_TRIES = 3
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       EN,
  input  logic       OK,
  input  logic [3:0] PIN,
  input  logic [1:0] COD,
  input  logic [3:0] VAL,
  input  logic [3:0] SALDO,
  output logic [1:0] COD_OUT,
  output logic [3:0] VAL_OUT,
  output logic [3:0] SALDO_OUT,
  output logic [4:0] ECRA,
  output logic       PAR
);

  localparam int TW = $clog2(MAX_TRIES + 1);

  state_t       state, state_nxt;
  logic [TW-1:0] tries, tries_nxt, tries_inc;
  logic [3:0]   bal, bal_nxt;
  logic [1:0]   cod_out, cod_nxt;
  logic [3:0]   val_out, val_nxt;
  logic [4:0]   ecra, ecra_nxt;
  alu_res_t     alu_res;

  mb_alu u_alu (
    .op  (COD),
    .val (VAL),
    .bal (bal),
    .res (alu_res)
  );

  assign tries_inc = tries + TW'(1);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= ST_IDLE;
      tries   <= '0;
      bal     <= 4'd0;
      cod_out <= 2'd0;
      val_out <= 4'd0;
      ecra    <= SCR_OFF;
    end else begin
      state   <= state_nxt;
      tries   <= tries_nxt;
      bal     <= bal_nxt;
      cod_out <= cod_nxt;
      val_out <= val_nxt;
      ecra    <= ecra_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tries_nxt = tries;
    bal_nxt   = bal;
    cod_nxt   = cod_out;
    val_nxt   = val_out;
    ecra_nxt  = ecra;
    if (!EN) begin
      // Card removed: same visible state as after reset.
      state_nxt = ST_IDLE;
      tries_nxt = '0;
      bal_nxt   = 4'd0;
      cod_nxt   = 2'd0;
      val_nxt   = 4'd0;
      ecra_nxt  = SCR_OFF;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_PIN;
          tries_nxt = '0;
          bal_nxt   = SALDO;
          cod_nxt   = 2'd0;
          val_nxt   = 4'd0;
          ecra_nxt  = SCR_ENTER_PIN;
        end
        ST_PIN: begin
          if (OK) begin
            if (PIN == PIN_CODE) begin
              state_nxt = ST_MENU;
              ecra_nxt  = SCR_MENU;
            end else begin
              tries_nxt = tries_inc;
              if (tries_inc == TW'(MAX_TRIES)) begin
                state_nxt = ST_BLOCK;
                ecra_nxt  = SCR_BLOCKED;
              end else begin
                ecra_nxt = SCR_PIN_WRONG;
              end
            end
          end
        end
        ST_MENU: begin
          if (OK) begin
            cod_nxt  = COD;
            val_nxt  = alu_res.cash;
            bal_nxt  = alu_res.bal;
            ecra_nxt = alu_res.scr;
            if (COD == OP_EXIT) state_nxt = ST_BYE;
          end
        end
        // BLOCK and BYE hold everything until the card is removed.
        default: ;
      endcase
    end
  end

  assign COD_OUT   = cod_out;
  assign VAL_OUT   = val_out;
  assign SALDO_OUT = bal;
  assign ECRA      = ecra;
  assign PAR       = ^bal;

endmodule

// File: tb/tb_mb_atm.sv
// Bench for mb_atm: every cycle the driver applies inputs at the falling
// edge, steps a behavioural model of the session, pushes the expected output
// vector, then compares at the next falling edge.
module tb_mb_atm;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       EN, OK;
  logic [3:0] PIN, VAL, SALDO;
  logic [1:0] COD;
  logic [1:0] COD_OUT;
  logic [3:0] VAL_OUT, SALDO_OUT;
  logic [4:0] ECRA;
  logic       PAR;

  // ---------------- clock / reset
  always #5 CLK = ~CLK;

  mb_atm dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .OK(OK), .PIN(PIN), .COD(COD),
    .VAL(VAL), .SALDO(SALDO), .COD_OUT(COD_OUT), .VAL_OUT(VAL_OUT),
    .SALDO_OUT(SALDO_OUT), .ECRA(ECRA), .PAR(PAR)
  );

  // ---------------- scoreboard
  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // model state: 0 idle, 1 pin, 2 menu, 3 block, 4 bye
  int m_st, m_bal, m_tries, m_cod, m_val, m_ecra;
  logic       cur_en;
  logic [3:0] cur_saldo;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] dut_vec();
    return {COD_OUT, VAL_OUT, SALDO_OUT, ECRA, PAR};
  endfunction

  function automatic logic [15:0] model_vec();
    logic [3:0] b;
    b = m_bal[3:0];
    return {m_cod[1:0], m_val[3:0], b, m_ecra[4:0], ^b};
  endfunction

  function automatic void model_clear();
    m_st = 0; m_bal = 0; m_tries = 0; m_cod = 0; m_val = 0; m_ecra = 0;
  endfunction

  function automatic void model_step(input logic en, input logic ok, input int pin,
                                     input int cod, input int val, input int saldo);
    if (!en) begin
      model_clear();
      return;
    end
    case (m_st)
      0: begin m_st = 1; m_bal = saldo; m_tries = 0; m_cod = 0; m_val = 0; m_ecra = 1; end
      1: if (ok) begin
        if (pin == 10) begin m_st = 2; m_ecra = 4; end
        else begin
          m_tries++;
          if (m_tries == 3) begin m_st = 3; m_ecra = 3; end
          else m_ecra = 2;
        end
      end
      2: if (ok) begin
        m_cod = cod; m_val = 0;
        case (cod)
          0: m_ecra = 5;
          1: if (val == 0) m_ecra = 10;
             else if (val > m_bal) m_ecra = 8;
             else begin m_bal -= val; m_val = val; m_ecra = 6; end
          2: if (val == 0) m_ecra = 10;
             else if (m_bal + val > 15) m_ecra = 9;
             else begin m_bal += val; m_ecra = 7; end
          default: begin m_st = 4; m_ecra = 11; end
        endcase
      end
      default: ;
    endcase
  endfunction

  // ---------------- driver tasks (entered and left on a falling edge)
  task automatic step(input string tag, input logic ok, input logic [3:0] pin,
                      input logic [1:0] cod, input logic [3:0] val);
    EN = cur_en; OK = ok; PIN = pin; COD = cod; VAL = val; SALDO = cur_saldo;
    model_step(cur_en, ok, int'(pin), int'(cod), int'(val), int'(cur_saldo));
    exp_q.push_back(model_vec());
    @(negedge CLK);
    OK = 1'b0;
    check(tag, dut_vec(), exp_q.pop_front());
  endtask

  task automatic set_en(input string tag, input logic en, input logic [3:0] saldo);
    cur_en = en; cur_saldo = saldo;
    step(tag, 1'b0, 4'd0, 2'd0, 4'd0);
  endtask

  task automatic ok_pin(input string tag, input logic [3:0] pin);
    step(tag, 1'b1, pin, 2'd0, 4'd0);
  endtask

  task automatic ok_op(input string tag, input logic [1:0] cod, input logic [3:0] val);
    step(tag, 1'b1, 4'd0, cod, val);
  endtask

  // ---------------- main sequence
  initial begin
    RST_N = 1'b0; EN = 1'b0; OK = 1'b0; PIN = 4'd0; COD = 2'd0; VAL = 4'd0; SALDO = 4'd0;
    cur_en = 1'b0; cur_saldo = 4'd0;
    model_clear();
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    exp_q.push_back(model_vec());
    check("reset_state", dut_vec(), exp_q.pop_front());

    // withdraw 5 from 15
    set_en("t2_start", 1'b1, 4'd15);
    ok_pin("t2_pin", 4'b1010);
    ok_op("t2_wdraw", 2'b01, 4'd5);
    check("t2_val_out", {12'd0, VAL_OUT}, 16'd5);
    check("t2_saldo_out", {12'd0, SALDO_OUT}, 16'd10);
    check("t2_par", {15'd0, PAR}, 16'd0);
    check("t2_ecra", {11'd0, ECRA}, 16'd6);
    check("t2_cod_out", {14'd0, COD_OUT}, 16'd1);

    // asynchronous reset mid-session
    #2 RST_N = 1'b0;
    #1;
    model_clear();
    exp_q.push_back(model_vec());
    check("t1_rst_async", dut_vec(), exp_q.pop_front());
    @(negedge CLK);
    cur_en = 1'b0; EN = 1'b0;
    RST_N = 1'b1;
    set_en("t1_idle_after", 1'b0, 4'd0);

    // lockout
    set_en("t3_start", 1'b1, 4'd7);
    ok_pin("t3_wrong1", 4'd0);
    check("t3_ecra1", {11'd0, ECRA}, 16'd2);
    ok_pin("t3_wrong2", 4'd0);
    check("t3_ecra2", {11'd0, ECRA}, 16'd2);
    ok_pin("t3_wrong3", 4'd0);
    check("t3_ecra3", {11'd0, ECRA}, 16'd3);
    ok_pin("t3_blocked", 4'b1010);
    check("t3_still_blocked", {11'd0, ECRA}, 16'd3);
    set_en("t3_en_off", 1'b0, 4'd7);
    check("t3_ecra_off", {11'd0, ECRA}, 16'd0);

    // OK without EN is ignored
    ok_pin("ok_no_en", 4'b1010);

    // insufficient funds, zero amount, SALDO change ignored mid-session
    set_en("t4_start", 1'b1, 4'd3);
    ok_pin("t4_pin", 4'b1010);
    cur_saldo = 4'd9;
    ok_op("t4_insuff", 2'b01, 4'd4);
    check("t4_ecra", {11'd0, ECRA}, 16'd8);
    check("t4_saldo", {12'd0, SALDO_OUT}, 16'd3);
    ok_op("t4_zero", 2'b01, 4'd0);
    check("t4_ecra_zero", {11'd0, ECRA}, 16'd10);
    set_en("t4_end", 1'b0, 4'd0);

    // deposit up to the boundary, then overflow
    set_en("t5_start", 1'b1, 4'd12);
    ok_pin("t5_pin", 4'b1010);
    ok_op("t5_dep", 2'b10, 4'd3);
    check("t5_saldo", {12'd0, SALDO_OUT}, 16'd15);
    check("t5_ecra", {11'd0, ECRA}, 16'd7);
    ok_op("t5_ovf", 2'b10, 4'd1);
    check("t5_ecra_ovf", {11'd0, ECRA}, 16'd9);
    ok_op("t5_dep_zero", 2'b10, 4'd0);

    // balance query, exit, OKs after exit
    ok_op("t6_bal", 2'b00, 4'd2);
    check("t6_ecra_bal", {11'd0, ECRA}, 16'd5);
    ok_op("t6_exit", 2'b11, 4'd0);
    check("t6_ecra_bye", {11'd0, ECRA}, 16'd11);
    ok_op("t6_after_bye", 2'b01, 4'd1);
    ok_pin("t6_after_bye2", 4'b1010);
    set_en("t6_end", 1'b0, 4'd0);

    // random sessions
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (!cur_en) begin
        if (r < 14) set_en("rnd_en_on", 1'b1, 4'($urandom_range(0, 15)));
        else        set_en("rnd_idle", 1'b0, 4'($urandom_range(0, 15)));
      end else if (r == 0) begin
        set_en("rnd_en_off", 1'b0, cur_saldo);
      end else if (r < 3) begin
        step("rnd_idle_cyc", 1'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
             4'($urandom_range(0, 15)));
      end else begin
        logic [3:0] p;
        p = (r < 15) ? 4'b1010 : 4'($urandom_range(0, 15));
        if (r == 19) cur_saldo = 4'($urandom_range(0, 15));
        step("rnd_ok", 1'b1, p, 2'($urandom_range(0, 2) + ((r == 18) ? 1 : 0)),
             4'($urandom_range(0, 15)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
